wbank_ctrl: RTL and testbench

WBANK_CTRL -- requirements
Module: wbank_ctrl

---
 rtl/wbank_ctrl_pkg.sv | 25 ++
 rtl/wbank_ctrl.sv | 133 +++++++++++++
 tb/tb_wbank_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/wbank_ctrl_pkg.sv
// rtl/wbank_ctrl_pkg.sv - shared types and constants for the write-bank controller
package wbank_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_FILL      = 2'd1,
      ST_SWITCH    = 2'd2,
      ST_WAIT_FREE = 2'd3
   } state_e;

   localparam int NUM_BANKS   = 3;
   localparam int MODE_FC_BIT = 3;

   // Words per bank: full capacity in FC mode, else row length clamped to capacity.
   function automatic int unsigned calc_target(input logic fc, input logic [7:0] pic,
                                               input int unsigned aw);
      int unsigned cap;
      int unsigned words;
      cap   = 32'd1 << aw;
      words = {21'd0, pic, 3'd0};
      if (fc) return cap;
      return (words < cap) ? words : cap;
   endfunction

endpackage

// File: rtl/wbank_ctrl.sv
// rtl/wbank_ctrl.sv - ping-pong-style write bank controller over three SRAM banks
module wbank_ctrl
   import wbank_ctrl_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic       SYS_CLK,
   input  logic       SYS_NRST,
   input  logic       DATA_SOP,
   input  logic       DATA_VLD,
   input  logic [7:0] PIC_SIZE,
   input  logic [3:0] MODE,
   input  logic       RBANK_RELEASE,
   output logic       WREADY,
   output logic       WBANK_UPDATE,
   output logic [1:0] WBANK_IDX,
   output logic [1:0] BANK_OCC
);

   localparam int CW = AW + 1;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] target;
   logic          fc_q;
   logic [7:0]    pic_q;
   logic [1:0]    idx_q;
   logic [1:0]    idx_d;
   logic [1:0]    occ_q;
   logic [1:0]    occ_d;
   logic          wready_q;
   logic          upd_q;
   logic          beat;
   logic          last_beat;
   logic          sop_fill;
   logic          unused_mode;

   assign unused_mode = ^MODE[2:0];

   assign target    = CW'(calc_target(fc_q, pic_q, AW));
   assign beat      = DATA_VLD & wready_q;
   assign last_beat = beat && (cnt_q == target - CW'(1));
   assign sop_fill  = MODE[MODE_FC_BIT] | (PIC_SIZE != 8'd0);

   always_comb begin
      idx_d = idx_q;
      if (state_q == ST_SWITCH)
         idx_d = (idx_q == 2'(NUM_BANKS - 1)) ? 2'd0 : idx_q + 2'd1;
   end

   // A release landing on the SWITCH cycle cancels that cycle's increment.
   always_comb begin
      occ_d = occ_q;
      if (DATA_SOP)
         occ_d = 2'd0;
      else if (state_q == ST_SWITCH) begin
         if (!RBANK_RELEASE)
            occ_d = occ_q + 2'd1;
      end else if (RBANK_RELEASE && (occ_q != 2'd0))
         occ_d = occ_q - 2'd1;
   end

   always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
      if (!SYS_NRST)
         occ_q <= 2'd0;
      else
         occ_q <= occ_d;
   end

   always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
      if (!SYS_NRST) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         fc_q     <= 1'b0;
         pic_q    <= 8'd0;
         idx_q    <= 2'd0;
         wready_q <= 1'b0;
         upd_q    <= 1'b0;
      end else if (DATA_SOP) begin
         fc_q     <= MODE[MODE_FC_BIT];
         pic_q    <= PIC_SIZE;
         cnt_q    <= '0;
         idx_q    <= 2'd0;
         upd_q    <= 1'b0;
         state_q  <= sop_fill ? ST_FILL : ST_IDLE;
         wready_q <= sop_fill;
      end else begin
         case (state_q)
            ST_IDLE: begin
               wready_q <= 1'b0;
               upd_q    <= 1'b0;
            end
            ST_FILL: begin
               if (last_beat) begin
                  cnt_q    <= '0;
                  state_q  <= ST_SWITCH;
                  wready_q <= 1'b0;
                  upd_q    <= 1'b1;
               end else if (beat)
                  cnt_q <= cnt_q + CW'(1);
            end
            ST_SWITCH: begin
               upd_q <= 1'b0;
               idx_q <= idx_d;
               if (occ_d == 2'(NUM_BANKS)) begin
                  state_q  <= ST_WAIT_FREE;
                  wready_q <= 1'b0;
               end else begin
                  state_q  <= ST_FILL;
                  wready_q <= 1'b1;
               end
            end
            ST_WAIT_FREE: begin
               if (occ_q < 2'(NUM_BANKS)) begin
                  state_q  <= ST_FILL;
                  wready_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               wready_q <= 1'b0;
               upd_q    <= 1'b0;
            end
         endcase
      end
   end

   assign WREADY       = wready_q;
   assign WBANK_UPDATE = upd_q;
   assign WBANK_IDX    = idx_q;
   assign BANK_OCC     = occ_q;

endmodule

// File: tb/tb_wbank_ctrl.sv
// tb/tb_wbank_ctrl.sv - directed self-checking bench for wbank_ctrl
module tb_wbank_ctrl;

   localparam int AW = 10;

   logic       clk  = 1'b0;
   logic       nrst = 1'b0;
   logic       sop  = 1'b0;
   logic       vld  = 1'b0;
   logic       rel  = 1'b0;
   logic [7:0] pic  = 8'd0;
   logic [3:0] mode = 4'd0;
   logic       wready;
   logic       upd;
   logic [1:0] idx;
   logic [1:0] occ;

   int n_chk  = 0;
   int n_fail = 0;
   int beats;
   int bidx;

   wbank_ctrl #(.AW(AW)) dut (
      .SYS_CLK      (clk),
      .SYS_NRST     (nrst),
      .DATA_SOP     (sop),
      .DATA_VLD     (vld),
      .PIC_SIZE     (pic),
      .MODE         (mode),
      .RBANK_RELEASE(rel),
      .WREADY       (wready),
      .WBANK_UPDATE (upd),
      .WBANK_IDX    (idx),
      .BANK_OCC     (occ)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [3:0] m, input logic [7:0] p);
      sop  = 1'b1;
      mode = m;
      pic  = p;
      tick();
      sop  = 1'b0;
   endtask

   // Counts accepted beats until the update pulse, optionally releasing a bank on that cycle.
   task automatic fill_bank(input logic rel_sw, output int nb, output int bi);
      logic w;
      logic done;
      nb   = 0;
      bi   = -1;
      done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         w = wready;
         tick();
         if (w) nb++;
         if (upd) begin
            bi = int'(idx);
            chk("wready_in_switch", wready, 0);
            rel = rel_sw;
            tick();
            rel = 1'b0;
            chk("update_one_cycle", upd, 0);
            done = 1'b1;
         end
      end
      if (!done) nb = -1;
   endtask

   initial begin
      #12;
      chk("rst_wready", wready, 0);
      chk("rst_update", upd, 0);
      chk("rst_idx", idx, 0);
      chk("rst_occ", occ, 0);
      nrst = 1'b1;
      vld  = 1'b1;
      repeat (5) tick();
      chk("idle_wready", wready, 0);
      chk("idle_update", upd, 0);

      // conv mode, PIC_SIZE=4 -> 32 beats per bank
      start(4'd0, 8'd4);
      chk("sop_wready", wready, 1);
      chk("sop_idx", idx, 0);
      for (int b = 0; b < 3; b++) begin
         fill_bank(1'b0, beats, bidx);
         chk("conv_beats", beats, 32);
         chk("conv_idx", bidx, b);
         chk("conv_occ", occ, b + 1);
      end
      chk("full_wready", wready, 0);
      repeat (3) tick();
      chk("full_wready_held", wready, 0);
      chk("full_occ", occ, 3);
      rel = 1'b1;
      tick();
      rel = 1'b0;
      chk("release_occ", occ, 2);
      chk("release_wready_1cyc", wready, 0);
      tick();
      chk("release_wready_2cyc", wready, 1);
      fill_bank(1'b0, beats, bidx);
      chk("bank4_beats", beats, 32);
      chk("bank4_idx", bidx, 0);

      // release coincident with SWITCH, then release at zero
      start(4'd0, 8'd4);
      fill_bank(1'b0, beats, bidx);
      fill_bank(1'b1, beats, bidx);
      chk("rel_switch_beats", beats, 32);
      chk("rel_switch_occ", occ, 1);
      chk("rel_switch_idx", idx, 2);
      rel = 1'b1;
      tick();
      rel = 1'b0;
      chk("rel_fill_occ", occ, 0);
      rel = 1'b1;
      tick();
      rel = 1'b0;
      chk("rel_zero_occ", occ, 0);

      // SOP after 17 beats of bank 1
      start(4'd0, 8'd4);
      fill_bank(1'b0, beats, bidx);
      repeat (17) tick();
      start(4'd0, 8'd4);
      chk("sop_mid_idx", idx, 0);
      chk("sop_mid_occ", occ, 0);
      chk("sop_mid_update", upd, 0);
      chk("sop_mid_wready", wready, 1);
      fill_bank(1'b0, beats, bidx);
      chk("sop_mid_beats", beats, 32);
      chk("sop_mid_bidx", bidx, 0);

      // SOP on the would-be last beat
      start(4'd0, 8'd4);
      repeat (31) tick();
      start(4'd0, 8'd4);
      chk("sop_last_update", upd, 0);
      fill_bank(1'b0, beats, bidx);
      chk("sop_last_beats", beats, 32);

      // FC mode and conv clamp
      start(4'd8, 8'd4);
      fill_bank(1'b0, beats, bidx);
      chk("fc_beats", beats, 1024);
      start(4'd0, 8'd200);
      fill_bank(1'b0, beats, bidx);
      chk("clamp_beats", beats, 1024);

      // PIC_SIZE=0 in conv mode parks in IDLE; FC ignores PIC_SIZE
      start(4'd0, 8'd0);
      chk("pic0_wready", wready, 0);
      repeat (4) tick();
      chk("pic0_wready_held", wready, 0);
      chk("pic0_update", upd, 0);
      start(4'd8, 8'd0);
      chk("fc_pic0_wready", wready, 1);

      // asynchronous reset mid-bank
      start(4'd0, 8'd4);
      fill_bank(1'b0, beats, bidx);
      repeat (5) tick();
      #2 nrst = 1'b0;
      #1;
      chk("arst_wready", wready, 0);
      chk("arst_update", upd, 0);
      chk("arst_idx", idx, 0);
      chk("arst_occ", occ, 0);
      #3 nrst = 1'b1;
      repeat (10) tick();
      chk("post_rst_wready", wready, 0);
      chk("post_rst_occ", occ, 0);
      start(4'd0, 8'd4);
      fill_bank(1'b0, beats, bidx);
      chk("post_rst_beats", beats, 32);
      chk("post_rst_bidx", bidx, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
